// File: rtl/plasma_sprite_renderer.sv
// Pixel colour stage: animated plasma/checker background, bouncing 16x16 sprite, 4-pixel white border.
// Latency: 1 cycle for colour and both syncs, which keeps them mutually aligned.
// No backpressure: one pixel is consumed and produced on every clock.
module plasma_sprite_renderer #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SPRITE_SPEED    = 1,
    parameter bit SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_active,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       freeze,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       h_sync_o,
    output logic       v_sync_o
);

    localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [10:0] BX_MAX    = 11'(H_ACTIVE - 16);
    localparam logic [10:0] BY_MAX    = 11'(V_ACTIVE - 16);
    localparam logic [10:0] SPD       = 11'(SPRITE_SPEED);
    localparam logic [9:0]  X_HI      = 10'(H_ACTIVE - 4);
    localparam logic [9:0]  Y_HI      = 10'(V_ACTIVE - 4);

    logic       v_sync_q;
    logic [7:0] frame_cnt;
    logic [9:0] bx, by;
    logic       dx_neg, dy_neg;
    logic       tick;
    logic [10:0] x_next, y_next;
    logic [7:0] u, v;
    logic       chk;
    logic [10:0] bx_end, by_end;
    logic       sprite_hit, border;
    logic [5:0] pix_c;

    // Returns {new direction (1 = moving towards 0), new position}; hits the limit exactly, then reverses.
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic neg,
                                              input logic [10:0] lim);
        logic [10:0] wide;
        wide = {1'b0, pos};
        if (!neg) begin
            if (wide + SPD >= lim) return {1'b1, lim[9:0]};
            return {1'b0, 10'(wide + SPD)};
        end
        if (wide <= SPD) return {1'b0, 10'd0};
        return {1'b1, 10'(wide - SPD)};
    endfunction

    assign tick   = (v_sync_q == SYNC_IDLE) && (v_sync != SYNC_IDLE);
    assign x_next = step_axis(bx, dx_neg, BX_MAX);
    assign y_next = step_axis(by, dy_neg, BY_MAX);

    assign u      = x[7:0] + frame_cnt;
    assign v      = y[7:0] + {frame_cnt[6:0], 1'b0};
    assign chk    = x[5] ^ y[5];
    assign bx_end = {1'b0, bx} + 11'd16;
    assign by_end = {1'b0, by} + 11'd16;

    assign sprite_hit = (x >= bx) && ({1'b0, x} < bx_end) && (y >= by) && ({1'b0, y} < by_end);
    assign border     = (x < 10'd4) || (x >= X_HI) || (y < 10'd4) || (y >= Y_HI);

    always_comb begin
        pix_c = 6'b000000;
        if (frame_active) begin
            if (border)          pix_c = 6'b111111;
            else if (sprite_hit) pix_c = 6'b110011;
            else                 pix_c = {u[7:6], v[7:6], (u[7:6] ^ v[7:6]) ^ {chk, chk}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r         <= 2'b00;
            g         <= 2'b00;
            b         <= 2'b00;
            h_sync_o  <= SYNC_IDLE;
            v_sync_o  <= SYNC_IDLE;
            v_sync_q  <= SYNC_IDLE;
            frame_cnt <= 8'd0;
            bx        <= 10'd0;
            by        <= 10'd0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
        end else begin
            {r, g, b} <= pix_c;
            h_sync_o  <= h_sync;
            v_sync_o  <= v_sync;
            v_sync_q  <= v_sync;
            // Pixels in the tick cycle still see the old state; tick falls in blanking.
            if (tick && !freeze) begin
                frame_cnt    <= frame_cnt + 8'd1;
                {dx_neg, bx} <= x_next;
                {dy_neg, by} <= y_next;
            end
        end
    end

endmodule
